hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, 15: max consecutive data-memory wait cycles before timeout; range 1..255.
REQ-002 Parameter CNT_W, 16: width of stall performance counter.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ID_rs  in  5  source register rs of the instruction in ID.
REQ-006 ID_rt  in  5  source register rt of the instruction in ID.
REQ-007 ID_UsesRt  in  1  ID instruction reads rt.
REQ-008 EX_Mem2R  in  1  instruction in EX is a load.
REQ-009 EX_Wesel  in  5  destination register of the instruction in EX.
REQ-010 EX_Redirect  in  1  taken branch/jump resolved in EX.
REQ-011 MEM_MemReq  in  1  instruction in MEM accesses data memory.
REQ-012 MemReady  in  1  data memory completes the access this cycle.
REQ-013 PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1 each  per-stage register enables.
REQ-014 IFID_Flush, IDEX_Flush  out  1 each  insert bubble into that register.
REQ-015 mem_timeout  out  1  sticky error flag.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with PC_Write=0.

Function
REQ-017 States: RUN, MEM_WAIT, HALT; outputs are combinational from state and inputs.
REQ-018 freeze = MEM_MemReq & ~MemReady, in RUN or MEM_WAIT.
REQ-019 Freeze forces all five enables to 0 and both flushes to 0, overriding load-use and redirect.
REQ-020 RUN -> MEM_WAIT when freeze; the wait counter loads 1.
REQ-021 MEM_WAIT holds while freeze; the wait counter increments each cycle.
REQ-022 MEM_WAIT -> RUN in the cycle after MemReady=1; the enables are 1 in the cycle MemReady=1.
REQ-023 MEM_WAIT -> HALT when freeze persists and the wait counter equals MAX_WAIT; mem_timeout is set to 1 on that edge.
REQ-024 HALT: all enables and flushes are 0 until reset; mem_timeout holds 1.
REQ-025 Load-use is EX_Mem2R & EX_Wesel!=0 & (EX_Wesel==ID_rs | (ID_UsesRt & EX_Wesel==ID_rt)).
REQ-026 Load-use without freeze or redirect: PC_Write=0, IFID_Write=0, IDEX_Flush=1, other enables 1; exactly one bubble per hazard.
REQ-027 Redirect without freeze: IFID_Flush=1, IDEX_Flush=1, all enables 1; redirect wins over a simultaneous load-use.
REQ-028 A redirect arriving during freeze is acted on in the first unfrozen cycle, because EX_Redirect is held by the frozen EX stage; no internal latch is used.
REQ-029 Default (no hazard): all enables 1, flushes 0.
REQ-030 stall_cnt increments on every edge where PC_Write=0, including HALT, and saturates at 2^CNT_W-1 with no wrap.
REQ-031 Register $0 never triggers load-use.

Reset
REQ-032 On rst: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0.
REQ-033 During rst, outputs follow REQ-029 for the current inputs.
REQ-034 Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately, without waiting for a clock edge.

Structure
REQ-035 The shared package pipe_pkg holds the state enum (RUN, MEM_WAIT, HALT) and the default MAX_WAIT constant.
REQ-036 Sub-module sat_counter (parameter W; ports clk, rst, inc, q) implements stall_cnt.
REQ-037 The wait counter is 8 bits, internal to the block.

Verification
REQ-038 Scenario 1: EX load to $5, ID_rs=5 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle all enables 1; stall_cnt=1.
REQ-039 Scenario 2: EX load to $0, ID_rs=0 -> no stall; stall_cnt remains 0.
REQ-040 Scenario 3: MEM_MemReq=1, MemReady low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the 4th; state returns to RUN; stall_cnt=3.
REQ-041 Scenario 4: MAX_WAIT=4, MemReady never asserts -> mem_timeout=1 after the 4th wait cycle; HALT holds all enables 0; rst then clears mem_timeout.
REQ-042 Scenario 5: EX_Redirect=1 together with load-use -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1; no load-use bubble.
REQ-043 Scenario 6: CNT_W=4, 20 stall cycles -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states and default limits.
// Imported by the hazard control unit and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam int MAX_WAIT_DEF = 15;
  localparam int WCNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Used for the stall performance counter.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: data-memory freeze, load-use bubble,
// redirect flush, memory-wait timeout and stall counting.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_Mem2R,
  input  logic [4:0]       EX_Wesel,
  input  logic             EX_Redirect,
  input  logic             MEM_MemReq,
  input  logic             MemReady,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             MEMWB_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WCNT_W-1:0] LP_MAX = WCNT_W'(MAX_WAIT);

  state_t            r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_timeout;

  logic w_freeze;
  logic w_lu;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_stall_inc;

  assign w_freeze = MEM_MemReq & ~MemReady
                  & (r_state != HALT);

  assign w_rs_hit = (EX_Wesel == ID_rs);
  assign w_rt_hit = ID_UsesRt & (EX_Wesel == ID_rt);
  assign w_lu     = EX_Mem2R & (EX_Wesel != 5'd0)
                  & (w_rs_hit | w_rt_hit);

  // Priority: halt/freeze > redirect > load-use > default.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    if (!rst) begin
      if ((r_state == HALT) || w_freeze) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        MEMWB_Write = 1'b0;
      end else if (EX_Redirect) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (w_lu) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_freeze) begin
            r_state <= MEM_WAIT;
            r_wcnt  <= WCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!w_freeze) begin
            r_state <= RUN;
            r_wcnt  <= '0;
          end else if (r_wcnt == LP_MAX) begin
            r_state   <= HALT;
            r_timeout <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign mem_timeout = r_timeout;
  assign w_stall_inc = ~PC_Write;

  sat_counter #(
    .W(CNT_W)
  ) u_stall (
    .clk(clk),
    .rst(rst),
    .inc(w_stall_inc),
    .q  (stall_cnt)
  );

endmodule
